// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Ports: clk, rst_n (async active-low), bcd[15:0] + load strobe into a shadow register, blank level;
//        outputs an[3:0], seg[6:0] {g..a}, dp (all active-low), frame_start pulse on scan wrap to digit 0.
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading-zero digits 3..1.
module seven_seg_scanner #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd,
    input  logic        load,
    input  logic        blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [15:0]   shadow;
    logic [15:0]   display;
    logic          pending;

    logic          tc;
    logic          wrap;
    logic [3:0]    nibble;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;
    logic          suppress;

    assign tc   = (presc == PRESC_LAST);
    assign wrap = tc && (idx == 2'd3);

    // Decimal point is never used by this display.
    assign dp = 1'b1;

    // Prescaler and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= 2'd0;
        end else if (tc) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Double buffer: shadow collects loads, display only changes at a frame
    // boundary so a frame never mixes old and new digits. A load landing on
    // the wrap edge bypasses the shadow and goes straight to the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= 16'h0000;
            display <= 16'h0000;
            pending <= 1'b0;
        end else begin
            if (load) begin
                shadow <= bcd;
            end
            if (wrap) begin
                if (load) begin
                    display <= bcd;
                end else if (pending) begin
                    display <= shadow;
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    always_comb begin
        nibble = 4'h0;
        case (idx)
            2'd0: nibble = display[3:0];
            2'd1: nibble = display[7:4];
            2'd2: nibble = display[11:8];
            2'd3: nibble = display[15:12];
            default: nibble = 4'h0;
        endcase
    end

    always_comb begin
        seg_next = 7'b0111111;
        case (nibble)
            4'd0: seg_next = 7'b1000000;
            4'd1: seg_next = 7'b1111001;
            4'd2: seg_next = 7'b0100100;
            4'd3: seg_next = 7'b0110000;
            4'd4: seg_next = 7'b0011001;
            4'd5: seg_next = 7'b0010010;
            4'd6: seg_next = 7'b0000010;
            4'd7: seg_next = 7'b1111000;
            4'd8: seg_next = 7'b0000000;
            4'd9: seg_next = 7'b0010000;
            default: seg_next = 7'b0111111; // invalid BCD shows "-"
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every more significant nibble are 0.
    always_comb begin
        suppress = 1'b0;
        case (idx)
            2'd3: suppress = (display[15:12] == 4'h0);
            2'd2: suppress = (display[15:8]  == 8'h00);
            2'd1: suppress = (display[15:4]  == 12'h000);
            default: suppress = 1'b0;
        endcase
    end
`else
    assign suppress = 1'b0;
`endif

    always_comb begin
        an_next = ~(4'b0001 << idx);
        if (blank || suppress) begin
            an_next = 4'b1111;
        end
    end

    // Registered outputs: one cycle behind index/display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an          <= 4'b1111;
            seg         <= 7'b1111111;
            frame_start <= 1'b0;
        end else begin
            an          <= an_next;
            seg         <= seg_next;
            frame_start <= wrap;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bcd;
    logic        load;
    logic        blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    int tests  = 0;
    int failed = 0;

    seven_seg_scanner #(.REFRESH_DIV(DIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bcd         (bcd),
        .load        (load),
        .blank       (blank),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Time-based: mk counts clock edges since reset release. The digit shown
    // after edge k is ((k-1)/DIV)%4 and every multiple of FRAME is a wrap.
    int          mk;
    logic [15:0] mdisp, msh;
    logic        mpend;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_fs;

    function automatic logic [6:0] digit_glyph(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic is_leading_zero(input logic [15:0] v, input int d);
`ifdef LEADING_ZERO_BLANK_EN
        return (d > 0) && ((v >> (4 * d)) == 16'h0000);
`else
        return (v == 16'hFFFF) && (d > 4); // never true: all digits always lit
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mk      = 0;
            mdisp   = 16'h0000;
            msh     = 16'h0000;
            mpend   = 1'b0;
            exp_an  = 4'b1111;
            exp_seg = 7'b1111111;
            exp_fs  = 1'b0;
        end else begin
            int d;
            logic w;
            mk      = mk + 1;
            d       = ((mk - 1) / DIV) % 4;
            exp_seg = digit_glyph(mdisp[4*d +: 4]);
            exp_an  = (blank || is_leading_zero(mdisp, d)) ? 4'b1111 : ~(4'b0001 << d);
            w       = (mk % FRAME) == 0;
            exp_fs  = w;
            if (load) msh = bcd;
            if (w) begin
                if (load) mdisp = bcd;
                else if (mpend) mdisp = msh;
                mpend = 1'b0;
            end else if (load) begin
                mpend = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s at edge %0d: got %b, expected %b", name, mk, act, req);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("model_an",  {12'h0, an},          {12'h0, exp_an});
        chk("model_seg", {9'h0, seg},          {9'h0, exp_seg});
        chk("model_dp",  {15'h0, dp},          16'h0001);
        chk("model_fs",  {15'h0, frame_start}, {15'h0, exp_fs});
    end

    // ---------------- directed stimulus ----------------
    task automatic at(input int k);
        int n = 0;
        while (mk != k && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (mk != k) begin
            tests++;
            failed++;
            $display("FAIL wait_edge: reached %0d, expected %0d", mk, k);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        bcd  = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bcd   = 16'h0000;
        load  = 1'b0;
        blank = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_an",  {12'h0, an},          16'h000F);
        chk("rst_seg", {9'h0, seg},          16'h007F);
        chk("rst_dp",  {15'h0, dp},          16'h0001);
        chk("rst_fs",  {15'h0, frame_start}, 16'h0000);
        rst_n = 1'b1;

        at(1);  chk("first_an", {12'h0, an}, 16'h000E); chk("first_seg", {9'h0, seg}, 16'h0040);
        at(5);  chk("slot1_an", {12'h0, an}, 16'h000D);
        at(16); chk("fs_wrap", {15'h0, frame_start}, 16'h0001);
        at(17); chk("wrap_an", {12'h0, an}, 16'h000E); chk("fs_drop", {15'h0, frame_start}, 16'h0000);

        // Mid-frame load 0x1234, committed at edge 32.
        at(20); do_load(16'h1234);
        at(30); chk("old_frame_seg", {9'h0, seg}, 16'h0040);
        at(33); chk("d0_4", {9'h0, seg}, 16'h0019); chk("d0_an", {12'h0, an}, 16'h000E);
        at(37); chk("d1_3", {9'h0, seg}, 16'h0030);
        at(41); chk("d2_2", {9'h0, seg}, 16'h0024);
        at(45); chk("d3_1", {9'h0, seg}, 16'h0079); chk("d3_an", {12'h0, an}, 16'h0007);

        // Two loads before one wrap: last wins.
        at(50); do_load(16'h1111);
        at(55); do_load(16'h5678);
        at(65); chk("ll_d0_8", {9'h0, seg}, 16'h0000);
        at(69); chk("ll_d1_7", {9'h0, seg}, 16'h0078);
        at(73); chk("ll_d2_6", {9'h0, seg}, 16'h0002);
        at(77); chk("ll_d3_5", {9'h0, seg}, 16'h0012);

        // Load coincident with the wrap edge (edge 80).
        at(79); do_load(16'h9999);
        at(81); chk("wrapload_seg", {9'h0, seg}, 16'h0010);

        // Invalid BCD digits.
        at(85); do_load(16'h00AF);
        at(97);  chk("inv_F", {9'h0, seg}, 16'h003F);
        at(101); chk("inv_A", {9'h0, seg}, 16'h003F);
`ifdef LEADING_ZERO_BLANK_EN
        at(105); chk("lz_d2_an", {12'h0, an}, 16'h000F);
        at(109); chk("lz_d3_an", {12'h0, an}, 16'h000F);
`else
        at(105); chk("nolz_d2_an", {12'h0, an}, 16'h000B);
        at(109); chk("nolz_d3_an", {12'h0, an}, 16'h0007);
`endif

        at(110); do_load(16'h0007);
        at(113); chk("seven_seg", {9'h0, seg}, 16'h0078); chk("seven_an", {12'h0, an}, 16'h000E);
`ifdef LEADING_ZERO_BLANK_EN
        at(121); chk("lz7_d2_an", {12'h0, an}, 16'h000F);
`else
        at(121); chk("nolz7_d2_an", {12'h0, an}, 16'h000B);
`endif

        // Blank for 10 cycles while showing 0x1234.
        at(122); do_load(16'h1234);
        at(130); blank = 1'b1;
        at(131); chk("blank_an", {12'h0, an}, 16'h000F);
        at(133); chk("blank_an2", {12'h0, an}, 16'h000F); chk("blank_seg", {9'h0, seg}, 16'h0030);
        at(140); blank = 1'b0;
        at(141); chk("unblank_an", {12'h0, an}, 16'h0007); chk("unblank_seg", {9'h0, seg}, 16'h0079);

        // Reset mid digit-2 with a pending load.
        at(146); do_load(16'h8888);
        at(154);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_an",  {12'h0, an},          16'h000F);
        chk("arst_seg", {9'h0, seg},          16'h007F);
        chk("arst_fs",  {15'h0, frame_start}, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        at(1);  chk("rel_an", {12'h0, an}, 16'h000E); chk("rel_seg", {9'h0, seg}, 16'h0040);
        at(17); chk("rel_wrap_seg", {9'h0, seg}, 16'h0040);
        at(40);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
